uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serialises one parallel byte per frame onto the UART TX line. Frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.
//  Sits directly downstream of baud_generator; every bit boundary is taken from its single-cycle baud_tick strobe.
//  Upstream logic hands over bytes with a valid/ready handshake.
// PARAMETERS
//  DATA_BITS   8  payload bits per frame; legal 5..8
//  PARITY_EN   0  1 = insert parity bit after data
//  PARITY_ODD  0  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//  STOP_BITS   1  stop bits per frame; legal 1 or 2
// PORTS
//  clk        in   1          system clock; one clock, all logic on posedge
//  rst        in   1          reset, synchronous, active-high
//  baud_tick  in   1          one-cycle bit-rate strobe from baud_generator
//  tx_valid   in   1          tx_data holds a byte to send
//  tx_data    in   DATA_BITS  byte to send; sampled only on accept
//  tx_ready   out  1          block can accept a byte (high only in IDLE)
//  tx         out  1          serial line; idle/mark = 1
//  tx_busy    out  1          frame in progress (state != IDLE)
//  tx_done    out  1          one-cycle pulse: frame's last stop bit finished
// BEHAVIOUR
//  Reset: state=IDLE, tx=1, tx_busy=0, tx_done=0, shift reg=0, bit count=0. tx_ready is 1 from the first cycle after reset.
//  Accept: tx_valid & tx_ready at a posedge. tx_data is latched into the shift reg and state goes to SYNC.
//   tx_valid is ignored when tx_ready=0; nothing is queued.
//  States (all transitions after the accept happen only on a cycle where baud_tick=1):
//   IDLE   tx=1. baud_tick is ignored.
//   SYNC   tx=1. Waits for the next tick so the start bit is a full bit period. tick -> START.
//   START  tx=0. tick -> DATA, bit count=0.
//   DATA   tx=shift[0]. On each tick: shift right, count+1. The tick after bit DATA_BITS-1 goes to PARITY if PARITY_EN, else STOP.
//   PARITY tx = XOR of the latched data, XOR PARITY_ODD. tick -> STOP.
//   STOP   tx=1. Lasts STOP_BITS ticks. The final tick -> IDLE, with tx_done=1 for exactly that one cycle.
//  tx, tx_busy and tx_done are registered. tx changes on the posedge that samples baud_tick=1, so every bit lasts exactly one tick period.
//   The one exception is a tick coinciding with accept: that tick is not counted.
//  Latency: from accept to the start-bit falling edge is 1 to one full tick period.
//   From accept to tx_done = 2 + DATA_BITS + PARITY_EN + STOP_BITS ticks (8N1: 11 ticks).
//  tx_busy=1 in every state except IDLE. tx_ready = ~tx_busy.
//   When tx_done=1, tx_ready is also 1 in the same cycle, so a back-to-back accept is legal there and enters SYNC.
//  Simultaneous events: rst has priority over everything. A baud_tick in the cycle of accept is not acted on (SYNC waits for the next one).
//  Reset mid-frame: the frame is abandoned. tx=1 on the next posedge, no tx_done pulse, and the byte is lost.
//  Bit counter width is $clog2(DATA_BITS); it wraps only via the explicit reset on START->DATA.
//  tx_data changes while busy have no effect on the frame in flight.
// TESTING
//  (all tests use baud_tick = 1 cycle high every 869 clk, matching baud_generator)
//  1. Reset: hold rst 3 cycles -> tx=1, tx_busy=0, tx_done=0, tx_ready=1. Then 5000 idle cycles -> tx stays 1.
//  2. 8N1, send 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1, each bit exactly 869 clk.
//     tx_done pulses once, 11 ticks after accept; tx_ready rises in the same cycle.
//  3. PARITY_EN=1, PARITY_ODD=0, send 0xA3 -> data bits 1,1,0,0,0,1,0,1, parity 0, stop 1.
//     Repeat with PARITY_ODD=1 -> parity 1.
//  4. Back-to-back: hold tx_valid with 0x0F then 0xF0 -> second accept happens in the tx_done cycle of the first.
//     Both frames arrive intact; tx_valid held while busy causes no extra accept.
//  5. Mid-frame reset: assert rst during DATA bit 3 of 0x00 -> tx=1 next cycle, no tx_done.
//     The next byte 0x81 then transmits correctly.
//  6. STOP_BITS=2, DATA_BITS=7, send 0x7F -> 7 data bits of 1, stop held for 2×869 clk.
//     tx_done comes 11 ticks after accept.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one DATA_BITS word per frame (start, LSB-first data, optional
// parity, STOP_BITS stop bits), every bit boundary taken from the baud_tick strobe.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);
    localparam logic ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 parity, parity_next;
    logic                 tx_next, busy_next, done_next;
    logic                 accept;

    assign tx_ready = ~tx_busy;
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            parity   <= parity_next;
            tx       <= tx_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
        end
    end

    // Outputs are computed one cycle ahead so tx/tx_busy/tx_done come straight from flops.
    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        parity_next   = parity;
        tx_next       = tx;
        busy_next     = tx_busy;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    shift_next  = tx_data;
                    parity_next = (^tx_data) ^ ODD;
                    busy_next   = 1'b1;
                    state_next  = SYNC;
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_next      = shift[0];
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next   = shift >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_next    = parity;
                            state_next = PARITY;
                        end else begin
                            tx_next       = 1'b1;
                            stop_cnt_next = 1'b0;
                            state_next    = STOP;
                        end
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations (8N1, 8E1, 8O1, 7N2) share one
// clock, reset and baud tick; every cycle of every frame is compared to a frame model.
module tb_uart_tx;
    localparam int NDUT = 4;
    localparam int TICK = 869;
    localparam int NB [NDUT] = '{8, 8, 8, 7};
    localparam int PE [NDUT] = '{0, 1, 1, 0};
    localparam int PO [NDUT] = '{0, 0, 1, 0};
    localparam int SB [NDUT] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       tx_valid [NDUT];
    logic [7:0] tx_data  [NDUT];
    logic       tx_ready [NDUT];
    logic       tx       [NDUT];
    logic       tx_busy  [NDUT];
    logic       tx_done  [NDUT];

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[0]),
        .tx_data(tx_data[0]), .tx_ready(tx_ready[0]), .tx(tx[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[1]),
        .tx_data(tx_data[1]), .tx_ready(tx_ready[1]), .tx(tx[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[2]),
        .tx_data(tx_data[2]), .tx_ready(tx_ready[2]), .tx(tx[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_7n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[3]),
        .tx_data(tx_data[3][6:0]), .tx_ready(tx_ready[3]), .tx(tx[3]),
        .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle strobe every TICK clocks, changed just after the posedge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt == TICK - 1) begin
                tick_cnt  = 0;
                baud_tick = 1'b1;
            end else begin
                tick_cnt  = tick_cnt + 1;
                baud_tick = 1'b0;
            end
        end
    end

    // Line levels of one frame in order: start, data LSB first, parity, stops.
    function automatic int build_frame(input logic [7:0] data, input int nb, input int pe,
                                       input int po, input int sb, output logic bits [16]);
        int n;
        int ones;
        n = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) bits[i] = 1'b1;
        bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < nb; i++) begin
            bits[n] = data[i];
            if (data[i]) ones = ones + 1;
            n = n + 1;
        end
        if (pe != 0) begin
            bits[n] = ((ones % 2) == 1) ^ (po != 0);
            n = n + 1;
        end
        for (int i = 0; i < sb; i++) begin
            bits[n] = 1'b1;
            n = n + 1;
        end
        return n;
    endfunction

    // Call just after a negedge; returns at the negedge of the tx_done cycle.
    task automatic send_frame(input int d, input logic [7:0] data, input bit hold,
                              input logic [7:0] next_data, input bit expect_immediate,
                              input bit align_tick, input string name);
        logic bits [16];
        int   bad_tx [16];
        int   len;
        int   k;
        int   cyc;
        int   waited;
        int   bad_busy;
        int   bad_done;
        bit   t_prev;
        bit   timed_out;
        logic exp_tx;
        logic ready_at_done;

        len = build_frame(data, NB[d], PE[d], PO[d], SB[d], bits);
        for (int j = 0; j < 16; j++) bad_tx[j] = 0;
        bad_busy = 0;
        bad_done = 0;
        ready_at_done = 1'b0;
        timed_out = 1'b0;

        if (align_tick) begin
            waited = 0;
            while (baud_tick !== 1'b1 && waited < 2 * TICK) begin
                @(negedge clk);
                waited = waited + 1;
            end
        end
        tx_data[d]  = data;
        tx_valid[d] = 1'b1;
        waited = 0;
        while (tx_ready[d] !== 1'b1 && waited < 20 * TICK) begin
            @(negedge clk);
            waited = waited + 1;
        end
        n_checks = n_checks + 1;
        if (waited >= 20 * TICK) begin
            $display("FAIL %s accept: tx_ready never rose, waited %0d cycles", name, waited);
            tx_valid[d] = 1'b0;
            return;
        end
        n_pass = n_pass + 1;
        if (expect_immediate) begin
            n_checks = n_checks + 1;
            if (waited !== 0) $display("FAIL %s accept_in_done_cycle: waited %0d, required 0", name, waited);
            else n_pass = n_pass + 1;
        end

        // A tick on the accept edge must not be counted.
        t_prev = 1'b0;
        @(negedge clk);
        if (hold) tx_data[d] = next_data;
        else tx_valid[d] = 1'b0;
        k = 0;
        cyc = 0;
        forever begin
            if (t_prev) k = k + 1;
            exp_tx = (k >= 1 && k <= len) ? bits[k-1] : 1'b1;
            if (tx[d] !== exp_tx) bad_tx[k] = bad_tx[k] + 1;
            if (tx_busy[d] !== (k <= len)) bad_busy = bad_busy + 1;
            if (tx_done[d] !== (k == len + 1)) bad_done = bad_done + 1;
            if (k == len + 1) begin
                ready_at_done = tx_ready[d];
                break;
            end
            t_prev = baud_tick;
            cyc = cyc + 1;
            if (cyc > (len + 2) * TICK + 10) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
        end

        n_checks = n_checks + 1;
        if (timed_out) $display("FAIL %s frame_timeout: reached tick %0d, required %0d", name, k, len + 1);
        else n_pass = n_pass + 1;
        for (int j = 0; j <= len + 1; j++) begin
            n_checks = n_checks + 1;
            if (bad_tx[j] !== 0)
                $display("FAIL %s tx_slot%0d: %0d cycles differ from level %0d, required 0",
                         name, j, bad_tx[j], (j >= 1 && j <= len) ? bits[j-1] : 1'b1);
            else n_pass = n_pass + 1;
        end
        n_checks = n_checks + 1;
        if (bad_busy !== 0) $display("FAIL %s tx_busy: %0d wrong cycles, required 0", name, bad_busy);
        else n_pass = n_pass + 1;
        n_checks = n_checks + 1;
        if (bad_done !== 0) $display("FAIL %s tx_done: %0d wrong cycles, required 0", name, bad_done);
        else n_pass = n_pass + 1;
        n_checks = n_checks + 1;
        if (ready_at_done !== 1'b1) $display("FAIL %s ready_at_done: got %b, required 1", name, ready_at_done);
        else n_pass = n_pass + 1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks = n_checks + 1;
            if (tx[d] !== 1'b1 || tx_busy[d] !== 1'b0 || tx_done[d] !== 1'b0 || tx_ready[d] !== 1'b1)
                $display("FAIL reset_state dut%0d: tx=%b busy=%b done=%b ready=%b, required 1 0 0 1",
                         d, tx[d], tx_busy[d], tx_done[d], tx_ready[d]);
            else n_pass = n_pass + 1;
        end
        rst = 1'b0;
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++)
                if (tx[d] !== 1'b1 || tx_busy[d] !== 1'b0 || tx_done[d] !== 1'b0) bad = bad + 1;
        end
        n_checks = n_checks + 1;
        if (bad !== 0) $display("FAIL idle_line: %0d bad samples, required 0", bad);
        else n_pass = n_pass + 1;
    endtask

    task automatic test_8n1();
        @(negedge clk);
        send_frame(0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, "8n1_55");
    endtask

    task automatic test_parity_stop();
        @(negedge clk);
        fork
            send_frame(1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b0, "8e1_a3");
            send_frame(2, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b0, "8o1_a3");
            send_frame(3, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0, "7n2_7f");
        join
    endtask

    task automatic test_back_to_back();
        int bad;
        @(negedge clk);
        send_frame(0, 8'h0F, 1'b1, 8'hF0, 1'b0, 1'b0, "b2b_0f");
        send_frame(0, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b0, "b2b_f0");
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_busy[0] !== 1'b0 || tx[0] !== 1'b1) bad = bad + 1;
        end
        n_checks = n_checks + 1;
        if (bad !== 0) $display("FAIL b2b_no_extra_accept: %0d busy samples, required 0", bad);
        else n_pass = n_pass + 1;
    endtask

    task automatic test_mid_reset();
        int  k;
        int  cyc;
        int  bad;
        bit  t_prev;
        @(negedge clk);
        tx_data[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        t_prev = 1'b0;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        k = 0;
        cyc = 0;
        // Slot 5 of the line is data bit 3 (after SYNC, start, bits 0..2).
        while (k < 5 && cyc < 8 * TICK) begin
            @(negedge clk);
            if (t_prev) k = k + 1;
            t_prev = baud_tick;
            cyc = cyc + 1;
        end
        repeat (100) @(negedge clk);
        n_checks = n_checks + 1;
        if (tx[0] !== 1'b0) $display("FAIL midrst_data_bit3: tx=%b, required 0", tx[0]);
        else n_pass = n_pass + 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks = n_checks + 1;
        if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || tx_done[0] !== 1'b0)
            $display("FAIL midrst_abandon: tx=%b busy=%b done=%b, required 1 0 0",
                     tx[0], tx_busy[0], tx_done[0]);
        else n_pass = n_pass + 1;
        bad = 0;
        repeat (2 * TICK) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_busy[0] !== 1'b0) bad = bad + 1;
        end
        n_checks = n_checks + 1;
        if (bad !== 0) $display("FAIL midrst_quiet: %0d bad samples, required 0", bad);
        else n_pass = n_pass + 1;
        send_frame(0, 8'h81, 1'b0, 8'h00, 1'b0, 1'b0, "midrst_81");
    endtask

    task automatic test_random();
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        @(negedge clk);
        fork
            send_frame(0, r0, 1'b0, 8'h00, 1'b0, 1'b1, "rand_8n1_on_tick");
            begin
                repeat ($urandom_range(0, TICK)) @(negedge clk);
                send_frame(1, r1, 1'b0, 8'h00, 1'b0, 1'b0, "rand_8e1");
            end
            begin
                repeat ($urandom_range(0, TICK)) @(negedge clk);
                send_frame(2, r2, 1'b0, 8'h00, 1'b0, 1'b0, "rand_8o1");
            end
            begin
                repeat ($urandom_range(0, TICK)) @(negedge clk);
                send_frame(3, r3, 1'b0, 8'h00, 1'b0, 1'b0, "rand_7n2");
            end
        join
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            tx_valid[d] = 1'b0;
            tx_data[d]  = 8'h00;
        end
        test_reset();
        test_8n1();
        test_parity_stop();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
